// File: rtl/fpu_pkg.sv
// Shared types and encodings for the FPU issue controller: operation codes, instruction
// classes, the iterative-unit FSM states and the retire-slot record.
package fpu_pkg;

  localparam int PIPE_LAT_DEF  = 3;
  localparam int NUM_FREGS_DEF = 32;

  typedef enum logic [4:0] {
    OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV, OP_FSQRT,
    OP_FSGNJ, OP_FSGNJN, OP_FSGNJX, OP_FMIN, OP_FMAX,
    OP_FCVT_W_S, OP_FCVT_WU_S, OP_FMV_X_W, OP_FEQ, OP_FLT,
    OP_FLE, OP_FCLASS, OP_FCVT_S_W, OP_FCVT_S_WU, OP_FMV_W_X,
    OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD
  } operations;

  typedef enum logic [1:0] {CLS_PIPE, CLS_ITER, CLS_ILLEGAL} op_class_t;

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_WB} div_state_t;

  // opcode[6:2]
  localparam logic [4:0] OPC_FMADD  = 5'b10000;
  localparam logic [4:0] OPC_FMSUB  = 5'b10001;
  localparam logic [4:0] OPC_FNMSUB = 5'b10010;
  localparam logic [4:0] OPC_FNMADD = 5'b10011;
  localparam logic [4:0] OPC_OPFP   = 5'b10100;

  // OP-FP funct5 [31:27]
  localparam logic [4:0] F5_FADD     = 5'b00000;
  localparam logic [4:0] F5_FSUB     = 5'b00001;
  localparam logic [4:0] F5_FMUL     = 5'b00010;
  localparam logic [4:0] F5_FDIV     = 5'b00011;
  localparam logic [4:0] F5_FSGNJ    = 5'b00100;
  localparam logic [4:0] F5_FMINMAX  = 5'b00101;
  localparam logic [4:0] F5_FSQRT    = 5'b01011;
  localparam logic [4:0] F5_FCMP     = 5'b10100;
  localparam logic [4:0] F5_FCVT_W_S = 5'b11000;
  localparam logic [4:0] F5_FCVT_S_W = 5'b11010;
  localparam logic [4:0] F5_FMV_X_W  = 5'b11100;
  localparam logic [4:0] F5_FMV_W_X  = 5'b11110;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       fp_dest;
  } retire_t;

endpackage

// File: rtl/fpu_decode.sv
// Combinational RV32F decoder: operation, issue class, which FP sources are read and
// whether the destination is an FP register.
module fpu_decode
  import fpu_pkg::*;
(
  input  logic [31:0] instruction,
  output operations   op_code,
  output op_class_t   op_class,
  output logic        use_rs1,
  output logic        use_rs2,
  output logic        use_rs3,
  output logic        fp_dest
);

  logic [4:0] opc;
  logic [4:0] funct5;
  logic [2:0] funct3;

  assign opc    = instruction[6:2];
  assign funct5 = instruction[31:27];
  assign funct3 = instruction[14:12];

  always_comb begin
    // NOTE: every output gets a default before any branch so no path can infer a latch.
    op_code  = OP_FADD;
    op_class = CLS_ILLEGAL;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    use_rs3  = 1'b0;
    fp_dest  = 1'b0;

    if (instruction[1:0] == 2'b11) begin
      case (opc)
        OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: begin
          op_class = CLS_PIPE;
          use_rs1  = 1'b1;
          use_rs2  = 1'b1;
          use_rs3  = 1'b1;
          fp_dest  = 1'b1;
          case (opc)
            OPC_FMADD:  op_code = OP_FMADD;
            OPC_FMSUB:  op_code = OP_FMSUB;
            OPC_FNMSUB: op_code = OP_FNMSUB;
            default:    op_code = OP_FNMADD;
          endcase
        end
        OPC_OPFP: begin
          op_class = CLS_PIPE;
          use_rs1  = 1'b1;
          use_rs2  = 1'b1;
          fp_dest  = 1'b1;
          case (funct5)
            F5_FADD: op_code = OP_FADD;
            F5_FSUB: op_code = OP_FSUB;
            F5_FMUL: op_code = OP_FMUL;
            F5_FDIV: begin
              op_code  = OP_FDIV;
              op_class = CLS_ITER;
            end
            F5_FSQRT: begin
              op_code  = OP_FSQRT;
              op_class = CLS_ITER;
              use_rs2  = 1'b0;
            end
            F5_FSGNJ: begin
              case (funct3)
                3'b000:  op_code = OP_FSGNJ;
                3'b001:  op_code = OP_FSGNJN;
                3'b010:  op_code = OP_FSGNJX;
                default: op_class = CLS_ILLEGAL;
              endcase
            end
            F5_FMINMAX: begin
              case (funct3)
                3'b000:  op_code = OP_FMIN;
                3'b001:  op_code = OP_FMAX;
                default: op_class = CLS_ILLEGAL;
              endcase
            end
            F5_FCVT_W_S: begin
              op_code = instruction[20] ? OP_FCVT_WU_S : OP_FCVT_W_S;
              fp_dest = 1'b0;
            end
            F5_FCMP: begin
              fp_dest = 1'b0;
              case (funct3)
                3'b010:  op_code = OP_FEQ;
                3'b001:  op_code = OP_FLT;
                3'b000:  op_code = OP_FLE;
                default: op_class = CLS_ILLEGAL;
              endcase
            end
            F5_FMV_X_W: begin
              fp_dest = 1'b0;
              case (funct3)
                3'b000:  op_code = OP_FMV_X_W;
                3'b001:  op_code = OP_FCLASS;
                default: op_class = CLS_ILLEGAL;
              endcase
            end
            F5_FCVT_S_W: begin
              op_code = instruction[20] ? OP_FCVT_S_WU : OP_FCVT_S_W;
              use_rs1 = 1'b0;
              use_rs2 = 1'b0;
            end
            F5_FMV_W_X: begin
              op_code = OP_FMV_W_X;
              use_rs1 = 1'b0;
              use_rs2 = 1'b0;
              if (funct3 != 3'b000) op_class = CLS_ILLEGAL;
            end
            default: op_class = CLS_ILLEGAL;
          endcase
        end
        default: op_class = CLS_ILLEGAL;
      endcase
    end

    // Dropped words must not touch the scoreboard or the hazard check.
    if (op_class == CLS_ILLEGAL) begin
      op_code = OP_FADD;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_rs3 = 1'b0;
      fp_dest = 1'b0;
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// In-order FPU issue controller: FP register scoreboard, fixed-latency retire shift
// register, iterative-unit FSM and arbitration of the shared FP write port.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int PIPE_LAT  = PIPE_LAT_DEF,
  parameter int NUM_FREGS = NUM_FREGS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instruction,
  output logic        pipe_issue,
  output logic        div_start,
  output logic [4:0]  op_code,
  input  logic        div_done,
  output logic        div_ack,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic        wb_sel,
  output logic        illegal_instr
);

  operations  dec_op;
  op_class_t  dec_class;
  logic       use_rs1, use_rs2, use_rs3, dec_fp_dest;

  fpu_decode u_decode (
    .instruction (instruction),
    .op_code     (dec_op),
    .op_class    (dec_class),
    .use_rs1     (use_rs1),
    .use_rs2     (use_rs2),
    .use_rs3     (use_rs3),
    .fp_dest     (dec_fp_dest)
  );

  logic [4:0] rs1, rs2, rs3, rd;
  assign rs1 = instruction[19:15];
  assign rs2 = instruction[24:20];
  assign rs3 = instruction[31:27];
  assign rd  = instruction[11:7];

  logic [NUM_FREGS-1:0] busy, busy_n;
  div_state_t           div_state, div_state_n;
  logic [4:0]           div_rd;
  retire_t              retire_sr [PIPE_LAT];
  retire_t              tail;
  logic                 hazard, ready_raw, issue, div_wr;

  assign tail = retire_sr[PIPE_LAT-1];

  // Hazards read the registered busy bits, so a same-cycle retire does not bypass.
  assign hazard = (use_rs1 && busy[rs1]) || (use_rs2 && busy[rs2]) ||
                  (use_rs3 && busy[rs3]) || (dec_fp_dest && busy[rd]);

  always_comb begin
    ready_raw = 1'b0;
    case (dec_class)
      CLS_PIPE:    ready_raw = !hazard && (div_state != DIV_WB);
      CLS_ITER:    ready_raw = !hazard && (div_state == DIV_IDLE);
      default:     ready_raw = 1'b1;
    endcase
  end

  assign instr_ready = rst_n && ready_raw;
  assign issue       = instr_valid && instr_ready;

  // The iterative result only takes the write port when no pipe result is retiring.
  always_comb begin
    div_state_n = div_state;
    div_wr      = 1'b0;
    case (div_state)
      DIV_IDLE: if (issue && dec_class == CLS_ITER) div_state_n = DIV_BUSY;
      DIV_BUSY: if (div_done) div_state_n = DIV_WB;
      DIV_WB: begin
        if (!tail.valid) begin
          div_wr      = 1'b1;
          div_state_n = DIV_IDLE;
        end
      end
      default: div_state_n = DIV_IDLE;
    endcase
  end

  // Clears are applied before the issue set, so retire+issue to one rd leaves it busy.
  always_comb begin
    busy_n = busy;
    if (tail.valid && tail.fp_dest) busy_n[tail.rd] = 1'b0;
    if (div_wr)                     busy_n[div_rd]  = 1'b0;
    if (issue && dec_fp_dest)       busy_n[rd]      = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the retire slots are control state (valid bits), so they are reset like any flop.
      busy          <= '0;
      div_state     <= DIV_IDLE;
      div_rd        <= '0;
      for (int i = 0; i < PIPE_LAT; i++) retire_sr[i] <= '0;
      pipe_issue    <= 1'b0;
      div_start     <= 1'b0;
      op_code       <= '0;
      illegal_instr <= 1'b0;
      wb_en         <= 1'b0;
      wb_rd         <= '0;
      wb_sel        <= 1'b0;
      div_ack       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values.
      busy          <= busy_n;
      div_state     <= div_state_n;
      pipe_issue    <= issue && (dec_class == CLS_PIPE);
      div_start     <= issue && (dec_class == CLS_ITER);
      illegal_instr <= issue && (dec_class == CLS_ILLEGAL);
      op_code       <= (issue && dec_class != CLS_ILLEGAL) ? dec_op : '0;
      if (issue && dec_class == CLS_ITER) div_rd <= rd;

      retire_sr[0] <= '{valid: issue && (dec_class == CLS_PIPE), rd: rd, fp_dest: dec_fp_dest};
      for (int i = 1; i < PIPE_LAT; i++) retire_sr[i] <= retire_sr[i-1];

      if (tail.valid) begin
        wb_en   <= tail.fp_dest;
        wb_rd   <= tail.rd;
        wb_sel  <= 1'b0;
        div_ack <= 1'b0;
      end else if (div_wr) begin
        wb_en   <= 1'b1;
        wb_rd   <= div_rd;
        wb_sel  <= 1'b1;
        div_ack <= 1'b1;
      end else begin
        wb_en   <= 1'b0;
        wb_sel  <= 1'b0;
        div_ack <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl: expected issues and writebacks are queued at the
// handshake and matched by a negedge monitor as the controller produces them.
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  localparam int PIPE_LAT = 3;
  localparam int K_PIPE = 0, K_ITER = 1, K_ILL = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instruction = '0;
  logic        div_done = 1'b0;
  logic        instr_ready, pipe_issue, div_start, div_ack, wb_en, wb_sel, illegal_instr;
  logic [4:0]  op_code, wb_rd;

  fpu_issue_ctrl #(.PIPE_LAT(PIPE_LAT), .NUM_FREGS(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instruction   (instruction),
    .pipe_issue    (pipe_issue),
    .div_start     (div_start),
    .op_code       (op_code),
    .div_done      (div_done),
    .div_ack       (div_ack),
    .wb_en         (wb_en),
    .wb_rd         (wb_rd),
    .wb_sel        (wb_sel),
    .illegal_instr (illegal_instr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  typedef struct {int cyc; int kind; logic [4:0] op;} iss_exp_t;
  typedef struct {int cyc; logic [4:0] rd;} wb_exp_t;

  iss_exp_t   iss_q [$];
  wb_exp_t    pipe_q [$];
  logic [4:0] div_q [$];

  // Iterative unit model: raises div_done div_delay cycles after div_start, holds until div_ack.
  int   div_delay = 4;
  int   div_cnt   = 0;
  logic div_flush = 1'b0;
  always @(posedge clk) begin
    if (div_flush) begin
      div_done <= 1'b0;
      div_cnt  <= 0;
    end else begin
      if (div_start)        div_cnt <= div_delay;
      else if (div_cnt > 1) div_cnt <= div_cnt - 1;
      else if (div_cnt == 1) begin
        div_done <= 1'b1;
        div_cnt  <= 0;
      end
      if (div_ack) div_done <= 1'b0;
    end
  end

  function automatic logic [2:0] kind_bits(input int kind);
    case (kind)
      K_PIPE:  return 3'b100;
      K_ITER:  return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  // Monitor
  iss_exp_t ie;
  wb_exp_t  we;
  logic [4:0] drd;
  int last_ack_cyc = -1;
  int n_wb = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (pipe_issue || div_start || illegal_instr) begin
        check("issue_expected", iss_q.size() > 0, 1);
        if (iss_q.size() > 0) begin
          ie = iss_q.pop_front();
          check("issue_cycle", cyc, ie.cyc);
          check("issue_kind", {pipe_issue, div_start, illegal_instr}, kind_bits(ie.kind));
          if (ie.kind != K_ILL) check("op_code", op_code, ie.op);
        end
      end
      if (div_ack && !wb_en) check("ack_with_wb", wb_en, 1);
      if (wb_en) begin
        n_wb++;
        if (!wb_sel) begin
          check("pipe_wb_expected", pipe_q.size() > 0, 1);
          check("pipe_wb_no_ack", div_ack, 0);
          if (pipe_q.size() > 0) begin
            we = pipe_q.pop_front();
            check("pipe_wb_rd", wb_rd, we.rd);
            check("pipe_wb_cycle", cyc, we.cyc);
          end
        end else begin
          check("div_wb_expected", div_q.size() > 0, 1);
          check("div_wb_ack", div_ack, 1);
          last_ack_cyc = cyc;
          if (div_q.size() > 0) begin
            drd = div_q.pop_front();
            check("div_wb_rd", wb_rd, drd);
          end
        end
      end
    end
  end

  function automatic logic [31:0] opfp(input logic [4:0] f5, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd);
    return {f5, 2'b00, rs2, rs1, f3, rd, 7'b1010011};
  endfunction

  function automatic logic [31:0] fmadd(input logic [4:0] rs3, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [4:0] rd);
    return {rs3, 2'b00, rs2, rs1, 3'b000, rd, 7'b1000011};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the handshake cycle.
  task automatic offer(input logic [31:0] w, input int kind, input logic fpd,
                       input logic [4:0] op, output int hs_cyc);
    int waited = 0;
    hs_cyc      = -1;
    instruction = w;
    instr_valid = 1'b1;
    while (hs_cyc < 0 && waited < 200) begin
      @(negedge clk);
      if (instr_ready) begin
        hs_cyc = cyc;
        iss_q.push_back('{cyc + 1, kind, op});
        if (kind == K_PIPE && fpd) pipe_q.push_back('{cyc + 1 + PIPE_LAT, w[11:7]});
        if (kind == K_ITER) div_q.push_back(w[11:7]);
      end
      waited++;
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    check("handshake_seen", hs_cyc >= 0, 1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((iss_q.size() + pipe_q.size() + div_q.size()) != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    check(tag, iss_q.size() + pipe_q.size() + div_q.size(), 0);
  endtask

  typedef struct {logic [31:0] w; int kind; logic fpd; operations op;} vec_t;

  initial begin
    int k, a, d, m, s, wb_before;
    vec_t tbl [$];

    // Reset state
    instruction = opfp(F5_FADD, 5'd2, 5'd1, 3'b000, 5'd3);
    instr_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", instr_ready, 0);
    check("rst_outputs", {pipe_issue, div_start, illegal_instr, wb_en, div_ack, wb_sel}, 0);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic FADD latency (checked by the monitor)
    offer(opfp(F5_FADD, 5'd2, 5'd1, 3'b000, 5'd3), K_PIPE, 1'b1, OP_FADD, k);
    drain("drain_fadd");

    // RAW stall: FMUL f4,f3,f1 waits until f3 retires
    offer(opfp(F5_FADD, 5'd2, 5'd1, 3'b000, 5'd3), K_PIPE, 1'b1, OP_FADD, k);
    offer(opfp(F5_FMUL, 5'd1, 5'd3, 3'b000, 5'd4), K_PIPE, 1'b1, OP_FMUL, m);
    check("raw_release_cycle", m, k + PIPE_LAT + 1);
    drain("drain_raw");

    // Iterative busy: second FDIV waits for div_ack, FADD slips in during DIV_BUSY
    div_delay = 8;
    offer(opfp(F5_FDIV, 5'd2, 5'd1, 3'b000, 5'd5), K_ITER, 1'b1, OP_FDIV, k);
    offer(opfp(F5_FADD, 5'd2, 5'd1, 3'b000, 5'd7), K_PIPE, 1'b1, OP_FADD, a);
    check("fadd_during_div", a, k + 1);
    offer(opfp(F5_FDIV, 5'd2, 5'd1, 3'b000, 5'd6), K_ITER, 1'b1, OP_FDIV, d);
    check("fdiv2_issue_cycle", d, k + 2 + div_delay + 2);
    check("fdiv1_ack_cycle", last_ack_cyc, k + 2 + div_delay + 2);
    drain("drain_div");

    // div_done lands while a pipe result retires; div write deferred behind pipe writes
    div_delay = 2;
    offer(opfp(F5_FDIV, 5'd2, 5'd1, 3'b000, 5'd5), K_ITER, 1'b1, OP_FDIV, k);
    offer(opfp(F5_FADD, 5'd2, 5'd1, 3'b000, 5'd9), K_PIPE, 1'b1, OP_FADD, a);
    offer(opfp(F5_FSUB, 5'd2, 5'd1, 3'b000, 5'd10), K_PIPE, 1'b1, OP_FSUB, m);
    check("collide_fadd_hs", a, k + 1);
    check("collide_fsub_hs", m, k + 2);
    drain("drain_collide");
    check("collide_div_wb_cycle", last_ack_cyc, k + 7);

    // Illegal words: accepted immediately, no issue, scoreboard unchanged
    s = cyc;
    offer(32'h0000_0013, K_ILL, 1'b0, OP_FADD, d);
    check("addi_accept_cycle", d, s);
    s = cyc;
    offer(opfp(F5_FADD, 5'd2, 5'd1, 3'b000, 5'd3), K_PIPE, 1'b1, OP_FADD, d);
    check("after_illegal_fadd", d, s);
    s = cyc;
    offer(opfp(5'b01111, 5'd2, 5'd1, 3'b000, 5'd8), K_ILL, 1'b0, OP_FADD, d);
    check("bad_funct5_accept", d, s);
    drain("drain_illegal");

    // Decode sweep across classes, source sets and destination kinds
    div_delay = 3;
    tbl.push_back('{opfp(F5_FSGNJ, 5'd2, 5'd1, 3'b010, 5'd11), K_PIPE, 1'b1, OP_FSGNJX});
    tbl.push_back('{opfp(F5_FMINMAX, 5'd2, 5'd1, 3'b001, 5'd12), K_PIPE, 1'b1, OP_FMAX});
    tbl.push_back('{opfp(F5_FCMP, 5'd2, 5'd1, 3'b010, 5'd5), K_PIPE, 1'b0, OP_FEQ});
    tbl.push_back('{opfp(F5_FCVT_W_S, 5'd1, 5'd1, 3'b001, 5'd6), K_PIPE, 1'b0, OP_FCVT_WU_S});
    tbl.push_back('{opfp(F5_FCVT_S_W, 5'd0, 5'd9, 3'b000, 5'd13), K_PIPE, 1'b1, OP_FCVT_S_W});
    tbl.push_back('{fmadd(5'd3, 5'd2, 5'd1, 5'd14), K_PIPE, 1'b1, OP_FMADD});
    tbl.push_back('{opfp(F5_FSQRT, 5'd0, 5'd1, 3'b000, 5'd15), K_ITER, 1'b1, OP_FSQRT});
    tbl.push_back('{opfp(F5_FMV_X_W, 5'd0, 5'd1, 3'b001, 5'd7), K_PIPE, 1'b0, OP_FCLASS});
    tbl.push_back('{opfp(F5_FSGNJ, 5'd2, 5'd1, 3'b011, 5'd16), K_ILL, 1'b0, OP_FADD});
    tbl.push_back('{opfp(F5_FMV_W_X, 5'd0, 5'd3, 3'b000, 5'd16), K_PIPE, 1'b1, OP_FMV_W_X});
    foreach (tbl[i]) offer(tbl[i].w, tbl[i].kind, tbl[i].fpd, tbl[i].op, d);
    drain("drain_sweep");

    // Reset in DIV_BUSY with two pipe ops in flight
    div_delay = 20;
    offer(opfp(F5_FDIV, 5'd2, 5'd1, 3'b000, 5'd5), K_ITER, 1'b1, OP_FDIV, k);
    offer(opfp(F5_FADD, 5'd2, 5'd1, 3'b000, 5'd11), K_PIPE, 1'b1, OP_FADD, a);
    offer(opfp(F5_FMUL, 5'd2, 5'd1, 3'b000, 5'd12), K_PIPE, 1'b1, OP_FMUL, m);
    rst_n = 1'b0;
    iss_q.delete();
    pipe_q.delete();
    div_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wb_before = n_wb;
    repeat (30) @(posedge clk);
    #1;
    check("no_wb_after_reset", n_wb, wb_before);
    s = cyc;
    offer(opfp(F5_FADD, 5'd12, 5'd5, 3'b000, 5'd11), K_PIPE, 1'b1, OP_FADD, d);
    check("post_reset_sb_clear", d, s);
    div_flush = 1'b1;
    @(posedge clk); #1;
    div_flush = 1'b0;
    div_delay = 3;
    s = cyc;
    offer(opfp(F5_FSQRT, 5'd0, 5'd1, 3'b000, 5'd5), K_ITER, 1'b1, OP_FSQRT, d);
    check("post_reset_fsm_idle", d, s);
    drain("drain_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
